// File: rtl/ex_stage.sv
// EX stage of the 5-stage MIPS pipeline: ALU control, ALU, branch-target adder, dest-reg mux,
// and the EX/MEM pipeline register with stall (hold) and flush (bubble) control.
module ex_stage #(
    parameter int unsigned DW      = 32,
    parameter int unsigned RW      = 5,
    parameter int unsigned IDEX_W  = 2 + 3 + 4 + 3 * DW + DW + 2 * RW,
    parameter int unsigned EXMEM_W = 2 + 3 + DW + DW + 1 + RW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_ex_valid,
    input  logic [IDEX_W-1:0]  id_ex_bundle,
    input  logic               stall,
    input  logic               flush,
    output logic               ex_mem_valid,
    output logic [EXMEM_W-1:0] ex_mem_bundle,
    output logic [DW-1:0]      ex_mem_wdata
);

    localparam int unsigned RdLsb  = 0;
    localparam int unsigned RtLsb  = RW;
    localparam int unsigned ImmLsb = 2 * RW;
    localparam int unsigned RtdLsb = ImmLsb + DW;
    localparam int unsigned RsdLsb = RtdLsb + DW;
    localparam int unsigned PcLsb  = RsdLsb + DW;
    localparam int unsigned ExLsb  = PcLsb + DW;
    localparam int unsigned MLsb   = ExLsb + 4;
    localparam int unsigned WbLsb  = MLsb + 3;

    typedef enum logic [2:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluNor,
        AluSlt,
        AluZero
    } alu_op_e;

    // ID/EX field decode
    logic [1:0]    wb_in;
    logic [2:0]    m_in;
    logic          reg_dst;
    logic [1:0]    alu_op_sel;
    logic          alu_src;
    logic [DW-1:0] pc_plus4;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm_sext;
    logic [RW-1:0] rt_idx;
    logic [RW-1:0] rd_idx;
    logic [5:0]    funct;

    assign wb_in      = id_ex_bundle[WbLsb +: 2];
    assign m_in       = id_ex_bundle[MLsb +: 3];
    assign reg_dst    = id_ex_bundle[ExLsb + 3];
    assign alu_op_sel = id_ex_bundle[ExLsb + 1 +: 2];
    assign alu_src    = id_ex_bundle[ExLsb];
    assign pc_plus4   = id_ex_bundle[PcLsb +: DW];
    assign rs_data    = id_ex_bundle[RsdLsb +: DW];
    assign rt_data    = id_ex_bundle[RtdLsb +: DW];
    assign imm_sext   = id_ex_bundle[ImmLsb +: DW];
    assign rt_idx     = id_ex_bundle[RtLsb +: RW];
    assign rd_idx     = id_ex_bundle[RdLsb +: RW];
    assign funct      = imm_sext[5:0];

    // ALU control
    alu_op_e alu_op;

    always_comb begin
        alu_op = AluZero;
        unique case (alu_op_sel)
            2'b00: alu_op = AluAdd;
            2'b01: alu_op = AluSub;
            2'b11: alu_op = AluOr;
            2'b10: begin
                case (funct)
                    6'b100000: alu_op = AluAdd;
                    6'b100010: alu_op = AluSub;
                    6'b100100: alu_op = AluAnd;
                    6'b100101: alu_op = AluOr;
                    6'b100111: alu_op = AluNor;
                    6'b101010: alu_op = AluSlt;
                    default:   alu_op = AluZero;
                endcase
            end
            default: alu_op = AluZero;
        endcase
    end

    // ALU datapath
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [DW-1:0] alu_result;
    logic          alu_zero;
    logic [DW-1:0] branch_target;
    logic [RW-1:0] dest_reg;

    assign op_a = rs_data;
    assign op_b = alu_src ? imm_sext : rt_data;

    always_comb begin
        alu_result = '0;
        unique case (alu_op)
            AluAdd:  alu_result = op_a + op_b;
            AluSub:  alu_result = op_a - op_b;
            AluAnd:  alu_result = op_a & op_b;
            AluOr:   alu_result = op_a | op_b;
            AluNor:  alu_result = ~(op_a | op_b);
            AluSlt:  alu_result = {{(DW-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            default: alu_result = '0;
        endcase
    end

    assign alu_zero      = (alu_result == '0);
    assign branch_target = pc_plus4 + {imm_sext[DW-3:0], 2'b00};
    assign dest_reg      = reg_dst ? rd_idx : rt_idx;

    // EX/MEM pipeline register
    logic          valid_q,  valid_d;
    logic [1:0]    wb_q,     wb_d;
    logic [2:0]    m_q,      m_d;
    logic [DW-1:0] target_q, target_d;
    logic [DW-1:0] result_q, result_d;
    logic          zero_q,   zero_d;
    logic [RW-1:0] dest_q,   dest_d;
    logic [DW-1:0] wdata_q,  wdata_d;

    // Priority: flush beats stall beats normal load
    always_comb begin
        valid_d  = valid_q;
        wb_d     = wb_q;
        m_d      = m_q;
        target_d = target_q;
        result_d = result_q;
        zero_d   = zero_q;
        dest_d   = dest_q;
        wdata_d  = wdata_q;
        if (flush) begin
            valid_d  = 1'b0;
            wb_d     = '0;
            m_d      = '0;
            target_d = '0;
            result_d = '0;
            zero_d   = 1'b0;
            dest_d   = '0;
            wdata_d  = '0;
        end else if (!stall) begin
            valid_d  = id_ex_valid;
            wb_d     = id_ex_valid ? wb_in : 2'b00;
            m_d      = id_ex_valid ? m_in : 3'b000;
            target_d = branch_target;
            result_d = alu_result;
            zero_d   = alu_zero;
            dest_d   = dest_reg;
            wdata_d  = rt_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            wb_q     <= '0;
            m_q      <= '0;
            target_q <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            dest_q   <= '0;
            wdata_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            wb_q     <= wb_d;
            m_q      <= m_d;
            target_q <= target_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            dest_q   <= dest_d;
            wdata_q  <= wdata_d;
        end
    end

    assign ex_mem_valid  = valid_q;
    assign ex_mem_bundle = {wb_q, m_q, target_q, result_q, zero_q, dest_q};
    assign ex_mem_wdata  = wdata_q;

endmodule
